// File: rtl/stream_distributor.sv
`default_nettype none
// ============================================================================
// Module      : stream_distributor
// Description : Fans one valid/ready stream out to NS sinks, each with a
//               one-deep registered output slot. Each accepted item goes to
//               exactly one free slot.
//               Optional macro STREAM_DISTRIBUTOR_ROUND_ROBIN_EN:
//                 defined     -> rotating priority starting at pointer rr
//                 not defined -> fixed priority, slot 0 highest
// Revision    : 1.0 - initial release
// ============================================================================
module stream_distributor #(
   parameter int NS = 2,
   parameter int DW = 32
) (
   input  logic                  clk,
   input  logic                  clk_en,
   input  logic                  rst,
   input  logic                  in_vld,
   output logic                  in_rdy,
   input  logic [DW-1:0]         in_dat,
   output logic [NS-1:0]         out_vld,
   input  logic [NS-1:0]         out_rdy,
   output logic [NS-1:0][DW-1:0] out_dat
);

   localparam int RW = (NS > 1) ? $clog2(NS) : 1;

   logic [NS-1:0]         r_vld;
   logic [NS-1:0][DW-1:0] r_dat;
   logic [NS-1:0]         w_avail;
   logic [RW-1:0]         w_sel;
   logic                  w_acc;

   // A slot can take a new item if it is empty or is being drained this cycle
   assign w_avail = ~r_vld | out_rdy;
   assign in_rdy  = clk_en & (|w_avail);
   assign w_acc   = in_vld & in_rdy;
   assign out_vld = r_vld;
   assign out_dat = r_dat;

`ifdef STREAM_DISTRIBUTOR_ROUND_ROBIN_EN
   localparam logic [RW-1:0] C_LAST = RW'(NS - 1);

   logic [RW-1:0] r_rr;

   // Cyclic search from r_rr; descending loop so the nearest hit wins
   always_comb begin
      logic [RW:0]   w_sum;
      logic [NS-1:0] w_shift;
      w_sel   = '0;
      w_sum   = '0;
      w_shift = '0;
      for (int k = NS - 1; k >= 0; k--) begin
         w_sum = {1'b0, r_rr} + (RW + 1)'(k);
         if (w_sum >= (RW + 1)'(NS)) begin
            w_sum = w_sum - (RW + 1)'(NS);
         end
         w_shift = w_avail >> w_sum[RW-1:0];
         if (w_shift[0]) begin
            w_sel = w_sum[RW-1:0];
         end
      end
   end

   // Pointer moves to the slot after the one just loaded, wrapping at NS-1
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rr <= '0;
      end else if (w_acc) begin
         r_rr <= (w_sel == C_LAST) ? '0 : w_sel + RW'(1);
      end
   end
`else
   // Fixed priority: lowest-index available slot; descending loop so lowest wins
   always_comb begin
      logic [NS-1:0] w_shift;
      w_sel   = '0;
      w_shift = '0;
      for (int k = NS - 1; k >= 0; k--) begin
         w_shift = w_avail >> k;
         if (w_shift[0]) begin
            w_sel = RW'(k);
         end
      end
   end
`endif

   // Per-slot load / drain; a load wins over a simultaneous drain
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_vld <= '0;
         r_dat <= '0;
      end else if (clk_en) begin
         for (int s = 0; s < NS; s++) begin
            if (w_acc && (w_sel == RW'(s))) begin
               r_vld[s] <= 1'b1;
               r_dat[s] <= in_dat;
            end else if (r_vld[s] && out_rdy[s]) begin
               r_vld[s] <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire
